// File: rtl/opt_frame_pkg.sv
// opt_frame_pkg: shared state encodings and default header bytes for the optical frame receiver.
// Used by opt_uart_bit_rx and opt_frame_rx. Parity support is selected with OPT_RX_PARITY_EN.
package opt_frame_pkg;

    localparam logic [7:0] SYNC0_DEF = 8'hEB;
    localparam logic [7:0] SYNC1_DEF = 8'h90;

    typedef enum logic [1:0] {
        FR_HUNT0,
        FR_HUNT1,
        FR_PAYLOAD,
        FR_CHK
    } frame_st_e;

    typedef enum logic [2:0] {
        BS_IDLE,
        BS_START,
        BS_DATA,
        BS_PAR,
        BS_STOP
    } bit_st_e;

endpackage

// File: rtl/opt_uart_bit_rx.sv
// opt_uart_bit_rx: synchronizes the serial line and samples one UART character per start edge.
// Ports:
//   i_clk_100M  system clock
//   i_reset_n   synchronous active-low reset
//   i_rx_d      asynchronous serial input, idle high
//   o_byte      assembled data byte, valid with o_byte_ok
//   o_byte_ok   1-cycle pulse on the stop-bit sample cycle, character good
//   o_byte_err  1-cycle pulse on the stop-bit sample cycle, stop (or parity) bad
// OPT_RX_PARITY_EN adds an even-parity bit after data bit 7.
module opt_uart_bit_rx
    import opt_frame_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input  logic       i_clk_100M,
    input  logic       i_reset_n,
    input  logic       i_rx_d,
    output logic [7:0] o_byte,
    output logic       o_byte_ok,
    output logic       o_byte_err
);

    // s_q[1] is the synchronized line, s_q[2] its previous value for edge detection
    logic [2:0]  s_q;
    bit_st_e     bs_q, bs_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
`ifdef OPT_RX_PARITY_EN
    logic        par_q, par_d;
`endif

    wire rx   = s_q[1];
    wire fall = s_q[2] & ~s_q[1];
    wire tick = cnt_q == 16'(CLK_DIV - 1);
    wire half = cnt_q == 16'(CLK_DIV / 2 - 1);

    always_ff @(posedge i_clk_100M) begin
        if (!i_reset_n) begin
            s_q   <= 3'b111;
            bs_q  <= BS_IDLE;
            cnt_q <= '0;
            bit_q <= '0;
            sh_q  <= '0;
`ifdef OPT_RX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            s_q   <= {s_q[1:0], i_rx_d};
            bs_q  <= bs_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q  <= sh_d;
`ifdef OPT_RX_PARITY_EN
            par_q <= par_d;
`endif
        end
    end

    always_comb begin
        bs_d       = bs_q;
        cnt_d      = cnt_q + 16'd1;
        bit_d      = bit_q;
        sh_d       = sh_q;
        o_byte_ok  = 1'b0;
        o_byte_err = 1'b0;
`ifdef OPT_RX_PARITY_EN
        par_d      = par_q;
`endif
        case (bs_q)
            BS_IDLE: begin
                cnt_d = '0;
                bs_d  = fall ? BS_START : BS_IDLE;
            end
            BS_START: if (half) begin
                cnt_d = '0;
                bs_d  = rx ? BS_IDLE : BS_DATA;
            end
            BS_DATA: if (tick) begin
                cnt_d = '0;
                sh_d  = {rx, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
`ifdef OPT_RX_PARITY_EN
                bs_d  = bit_q == 3'd7 ? BS_PAR : BS_DATA;
`else
                bs_d  = bit_q == 3'd7 ? BS_STOP : BS_DATA;
`endif
            end
`ifdef OPT_RX_PARITY_EN
            BS_PAR: if (tick) begin
                cnt_d = '0;
                par_d = ^{sh_q, rx};
                bs_d  = BS_STOP;
            end
`endif
            BS_STOP: if (tick) begin
                cnt_d      = '0;
                bs_d       = BS_IDLE;
`ifdef OPT_RX_PARITY_EN
                o_byte_ok  = rx & ~par_q;
`else
                o_byte_ok  = rx;
`endif
                o_byte_err = ~o_byte_ok;
            end
            default: bs_d = BS_IDLE;
        endcase
    end

    assign o_byte = sh_q;

endmodule

// File: rtl/opt_frame_rx.sv
// opt_frame_rx: optical-link frame receiver; hunts the 2-byte header, streams payload, checks the 8-bit sum.
// Ports:
//   i_clk_100M    system clock
//   i_reset_n     synchronous active-low reset
//   i_rx_d        asynchronous serial line, idle high
//   o_fs_start    1-cycle pulse: header accepted
//   o_byte        payload byte, valid with o_byte_vld
//   o_byte_vld    1-cycle pulse per payload byte
//   o_frame_done  1-cycle pulse: frame checked or aborted
//   o_frame_ok    checksum match, qualifies o_frame_done
//   o_err_stop    1-cycle pulse: stop (or parity) bit bad
// OPT_RX_PARITY_EN selects 8E1 characters instead of 8N1.
module opt_frame_rx
    import opt_frame_pkg::*;
#(
    parameter int         CLK_DIV     = 20,
    parameter logic [7:0] SYNC0       = SYNC0_DEF,
    parameter logic [7:0] SYNC1       = SYNC1_DEF,
    parameter int         PAYLOAD_LEN = 16
) (
    input  logic       i_clk_100M,
    input  logic       i_reset_n,
    input  logic       i_rx_d,
    output logic       o_fs_start,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_frame_done,
    output logic       o_frame_ok,
    output logic       o_err_stop
);

    logic [7:0] b;
    logic       ok, err;

    opt_uart_bit_rx #(.CLK_DIV(CLK_DIV)) u_bit (
        .i_clk_100M (i_clk_100M),
        .i_reset_n  (i_reset_n),
        .i_rx_d     (i_rx_d),
        .o_byte     (b),
        .o_byte_ok  (ok),
        .o_byte_err (err)
    );

    frame_st_e  st_q, st_d;
    logic [7:0] sum_q, sum_d, cnt_q, cnt_d, byte_d;
    logic       fs_d, vld_d, done_d, fok_d, es_d;

    // outputs are registered so every pulse lands one cycle after the stop-bit sample
    always_ff @(posedge i_clk_100M) begin
        if (!i_reset_n) begin
            st_q         <= FR_HUNT0;
            sum_q        <= '0;
            cnt_q        <= '0;
            o_fs_start   <= 1'b0;
            o_byte       <= '0;
            o_byte_vld   <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_ok   <= 1'b0;
            o_err_stop   <= 1'b0;
        end else begin
            st_q         <= st_d;
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            o_fs_start   <= fs_d;
            o_byte       <= byte_d;
            o_byte_vld   <= vld_d;
            o_frame_done <= done_d;
            o_frame_ok   <= fok_d;
            o_err_stop   <= es_d;
        end
    end

    wire in_frame = st_q == FR_PAYLOAD || st_q == FR_CHK;

    always_comb begin
        st_d = st_q;
        case (st_q)
            FR_HUNT0:   st_d = ok && b == SYNC0 ? FR_HUNT1 : FR_HUNT0;
            FR_HUNT1:   st_d = !ok ? FR_HUNT1 : b == SYNC1 ? FR_PAYLOAD : b == SYNC0 ? FR_HUNT1 : FR_HUNT0;
            FR_PAYLOAD: st_d = err ? FR_HUNT0 : ok && cnt_q == 8'(PAYLOAD_LEN - 1) ? FR_CHK : FR_PAYLOAD;
            FR_CHK:     st_d = ok || err ? FR_HUNT0 : FR_CHK;
            default:    st_d = FR_HUNT0;
        endcase
    end

    always_comb begin
        fs_d   = ok && st_q == FR_HUNT1 && b == SYNC1;
        vld_d  = ok && st_q == FR_PAYLOAD;
        byte_d = vld_d ? b : 8'h00;
        fok_d  = ok && st_q == FR_CHK && b == sum_q;
        done_d = (ok && st_q == FR_CHK) || (err && in_frame);
        es_d   = err;
        sum_d  = fs_d ? 8'h00 : vld_d ? sum_q + b : sum_q;
        cnt_d  = fs_d ? 8'h00 : vld_d ? cnt_q + 8'd1 : cnt_q;
    end

endmodule

// File: tb/tb_opt_frame_rx.sv
// tb_opt_frame_rx: directed self-checking bench for opt_frame_rx (CLK_DIV=20, PAYLOAD_LEN=16).
module tb_opt_frame_rx;

    localparam int DIV = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       o_fs_start, o_byte_vld, o_frame_done, o_frame_ok, o_err_stop;
    logic [7:0] o_byte;

    opt_frame_rx #(.CLK_DIV(DIV), .PAYLOAD_LEN(16)) dut (
        .i_clk_100M   (clk),
        .i_reset_n    (rst_n),
        .i_rx_d       (rx),
        .o_fs_start   (o_fs_start),
        .o_byte       (o_byte),
        .o_byte_vld   (o_byte_vld),
        .o_frame_done (o_frame_done),
        .o_frame_ok   (o_frame_ok),
        .o_err_stop   (o_err_stop)
    );

    always #5 clk = ~clk;

    int n_fs = 0, n_vld = 0, n_done = 0, n_ok = 0, n_err = 0, n_stray = 0;
    logic [7:0] got[1024];

    always @(negedge clk) begin
        if (o_fs_start) n_fs++;
        if (o_byte_vld) begin
            got[n_vld] = o_byte;
            n_vld++;
        end
        if (o_frame_done) n_done++;
        if (o_frame_done && o_frame_ok) n_ok++;
        if (o_frame_ok && !o_frame_done) n_stray++;
        if (o_err_stop) n_err++;
    end

    int errors = 0, checks = 0;
    int b_fs, b_vld, b_done, b_ok, b_err;
    logic [7:0] pl[16];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mark();
        b_fs = n_fs; b_vld = n_vld; b_done = n_done; b_ok = n_ok; b_err = n_err;
    endtask

    task automatic deltas(input string tag, input int fs, input int vld, input int done, input int ok, input int er);
        chk({tag, "_fs"}, n_fs - b_fs, fs);
        chk({tag, "_vld"}, n_vld - b_vld, vld);
        chk({tag, "_done"}, n_done - b_done, done);
        chk({tag, "_ok"}, n_ok - b_ok, ok);
        chk({tag, "_err"}, n_err - b_err, er);
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic stop, input logic pflip);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(v[i]);
`ifdef OPT_RX_PARITY_EN
        bit_time(^v ^ pflip);
`else
        if (pflip) bit_time(1'b1);
`endif
        bit_time(stop);
    endtask

    task automatic send_frame(input logic [7:0] c);
        send_byte(8'hEB, 1'b1, 1'b0);
        send_byte(8'h90, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) send_byte(pl[i], 1'b1, 1'b0);
        send_byte(c, 1'b1, 1'b0);
        idle(40);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_fs"}, int'(o_fs_start), 0);
        chk({tag, "_byte"}, int'(o_byte), 0);
        chk({tag, "_vld"}, int'(o_byte_vld), 0);
        chk({tag, "_done"}, int'(o_frame_done), 0);
        chk({tag, "_ok"}, int'(o_frame_ok), 0);
        chk({tag, "_err"}, int'(o_err_stop), 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pl[i] = 8'(i + 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(30);

        // 1: good frame 01..10, sum 0x88
        mark();
        send_frame(8'h88);
        deltas("t1", 1, 16, 1, 1, 0);
        for (int i = 0; i < 16; i++) chk($sformatf("t1_byte%0d", i), int'(got[b_vld + i]), i + 1);

        // 2: checksum off by one
        mark();
        send_frame(8'h89);
        deltas("t2", 1, 16, 1, 0, 0);

        // 3: extra EB before header, 33 EB 90 inside payload; sum 0x30
        pl[0] = 8'h33; pl[1] = 8'hEB; pl[2] = 8'h90;
        mark();
        send_byte(8'hEB, 1'b1, 1'b0);
        send_frame(8'h30);
        deltas("t3", 1, 16, 1, 1, 0);
        chk("t3_byte1", int'(got[b_vld + 1]), 'hEB);
        chk("t3_byte2", int'(got[b_vld + 2]), 'h90);
        for (int i = 0; i < 3; i++) pl[i] = 8'(i + 1);

        // 4: 8-cycle low glitch on idle line
        mark();
        rx = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        idle(60);
        deltas("t4g", 0, 0, 0, 0, 0);
        send_frame(8'h88);
        deltas("t4", 1, 16, 1, 1, 0);

        // 5: payload byte 5 with bad stop bit aborts the frame
        mark();
        send_byte(8'hEB, 1'b1, 1'b0);
        send_byte(8'h90, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(pl[i], 1'b1, 1'b0);
        send_byte(pl[4], 1'b0, 1'b0);
        idle(60);
        deltas("t5a", 1, 4, 1, 0, 1);
        mark();
        send_frame(8'h88);
        deltas("t5", 1, 16, 1, 1, 0);

        // 6: one-cycle reset mid-payload
        mark();
        send_byte(8'hEB, 1'b1, 1'b0);
        send_byte(8'h90, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(pl[i], 1'b1, 1'b0);
        rx = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("t6r");
        idle(40);
        deltas("t6a", 1, 5, 0, 0, 0);
        mark();
        send_frame(8'h88);
        deltas("t6", 1, 16, 1, 1, 0);

`ifdef OPT_RX_PARITY_EN
        // odd parity on payload byte 3 aborts the frame
        mark();
        send_byte(8'hEB, 1'b1, 1'b0);
        send_byte(8'h90, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) send_byte(pl[i], 1'b1, 1'b0);
        send_byte(pl[2], 1'b1, 1'b1);
        idle(60);
        deltas("tpar", 1, 2, 1, 0, 1);
`endif

        chk("stray_ok", n_stray, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
